// File: rtl/maxpool_avgpool_stage_if.sv
// maxpool_avgpool_stage_if: row stream into and pooled rows out of the 2x2 pooling stage.
interface maxpool_avgpool_stage_if #(parameter int DESIGN_SIZE = 4, parameter int DWIDTH = 8);
  logic                          enable_pool;
  logic                          pool_type;
  logic                          in_data_available;
  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
  logic [DESIGN_SIZE-1:0]        validity_mask;
  logic [DESIGN_SIZE*DWIDTH-1:0] out_data;
  logic                          out_data_available;
  logic                          done_pool;
  modport master (output enable_pool, pool_type, in_data_available, inp_data, validity_mask,
                  input out_data, out_data_available, done_pool);
  modport slave (input enable_pool, pool_type, in_data_available, inp_data, validity_mask,
                 output out_data, out_data_available, done_pool);
endinterface

// File: rtl/maxpool_avgpool_stage.sv
// maxpool_avgpool_stage: 2x2 max/average pooling over tiles of DESIGN_SIZE rows, or combinational bypass.
module maxpool_avgpool_stage #(parameter int DESIGN_SIZE = 4, parameter int DWIDTH = 8) (
  input logic clk,
  input logic resetn,
  maxpool_avgpool_stage_if.slave p
);
  localparam int H  = DESIGN_SIZE / 2;
  localparam int CW = $clog2(DESIGN_SIZE + 1);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;
  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [H-1:0][DWIDTH+1:0] r_part, w_red;
  logic [H*DWIDTH-1:0]     w_lo;
  logic [DESIGN_SIZE*DWIDTH-1:0] r_out;
  logic                    r_valid, w_last, w_done;
  for (genvar k = 0; k < H; k++) begin : g_lane
    logic signed [DWIDTH-1:0] w_a, w_b, w_q;
    logic signed [DWIDTH+1:0] w_r, w_p, w_c;
    assign w_a = p.validity_mask[2*k]   ? p.inp_data[2*k*DWIDTH +: DWIDTH]     : '0;
    assign w_b = p.validity_mask[2*k+1] ? p.inp_data[(2*k+1)*DWIDTH +: DWIDTH] : '0;
    assign w_r = p.pool_type ? w_a + w_b : (w_a > w_b ? w_a : w_b);
    assign w_red[k] = w_r;
    assign w_p = r_part[k];
    // Sum of four DWIDTH values fits DWIDTH+2 bits; the floor average fits back in DWIDTH.
    assign w_c = p.pool_type ? w_p + w_r : (w_p > w_r ? w_p : w_r);
    assign w_q = DWIDTH'(w_c >>> 2);
    assign w_lo[k*DWIDTH +: DWIDTH] = p.pool_type ? w_q : w_c[DWIDTH-1:0];
  end
  assign w_last = r_state == S_HOLD && r_cnt == CW'(DESIGN_SIZE - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else r_state <= p.enable_pool ? w_next : S_IDLE;
  end
  always_comb begin
    w_next = !p.in_data_available ? (r_state == S_DONE ? S_IDLE : r_state)
           : r_state == S_HOLD ? (w_last ? S_DONE : S_IDLE) : S_HOLD;
  end
  always_comb begin
    w_done = r_state == S_DONE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_part  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (!p.enable_pool) begin
      r_cnt   <= '0;
      r_part  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= p.in_data_available && r_state == S_HOLD;
      r_cnt   <= r_state == S_DONE ? CW'(p.in_data_available) : r_cnt + CW'(p.in_data_available);
      if (p.in_data_available && r_state != S_HOLD) r_part <= w_red;
      if (p.in_data_available && r_state == S_HOLD) r_out <= {{(DESIGN_SIZE*DWIDTH-H*DWIDTH){1'b0}}, w_lo};
    end
  end
  assign p.out_data           = p.enable_pool ? r_out : p.inp_data;
  assign p.out_data_available = p.enable_pool ? r_valid : p.in_data_available;
  assign p.done_pool          = p.enable_pool ? w_done : 1'b1;
endmodule

// File: tb/tb_maxpool_avgpool_stage.sv
// tb_maxpool_avgpool_stage: scoreboard bench; expected pooled rows queued at the odd row, checked on output.
module tb_maxpool_avgpool_stage;
  logic clk = 0, resetn = 0;
  always #5 clk = ~clk;
  maxpool_avgpool_stage_if #(.DESIGN_SIZE(4), .DWIDTH(8)) p();
  maxpool_avgpool_stage #(.DESIGN_SIZE(4), .DWIDTH(8)) dut (.clk(clk), .resetn(resetn), .p(p));
  typedef struct {logic [31:0] d; logic done; int due;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, cyc = 0, n_rows = 0, n_done = 0;
  logic [31:0] r_even;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic logic [31:0] row(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction
  function automatic int lane(logic [31:0] x, logic [3:0] m, int i);
    return m[i] ? int'($signed(x[i*8 +: 8])) : 0;
  endfunction
  function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [3:0] m, logic pt);
    logic [31:0] r = '0;
    for (int k = 0; k < 2; k++) begin
      int v[4];
      int res;
      v[0] = lane(a, m, 2*k); v[1] = lane(a, m, 2*k+1);
      v[2] = lane(b, m, 2*k); v[3] = lane(b, m, 2*k+1);
      if (pt) res = (v[0] + v[1] + v[2] + v[3]) >>> 2;
      else begin
        res = v[0];
        for (int j = 1; j < 4; j++) if (v[j] > res) res = v[j];
      end
      r[k*8 +: 8] = res[7:0];
    end
    return r;
  endfunction
  task automatic drive(logic [31:0] d, logic pt);
    p.inp_data = d; p.pool_type = pt; p.in_data_available = 1;
    if (n_rows % 2 == 0) r_even = d;
    else q.push_back('{model(r_even, d, p.validity_mask, pt), n_rows == 3, cyc + 1});
    n_rows = (n_rows + 1) % 4;
    @(posedge clk); #1 p.in_data_available = 0;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (resetn && p.enable_pool) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      chk("missing_out", 0, 1);
      void'(q.pop_front());
    end
    if (p.done_pool) n_done++;
    if (p.out_data_available) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_data", p.out_data, e.d);
        chk("done_pool", {31'b0, p.done_pool}, {31'b0, e.done});
        chk("latency", cyc, e.due);
      end
    end else if (p.done_pool) chk("done_alone", 1, 0);
  end
  initial begin
    p.enable_pool = 1; p.pool_type = 0; p.in_data_available = 0;
    p.inp_data = '0; p.validity_mask = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", p.out_data, 0);
    chk("rst_avail", {31'b0, p.out_data_available}, 0);
    chk("rst_done", {31'b0, p.done_pool}, 0);
    resetn = 1;
    idle(1);
    drive(row(1, 2, 3, 4), 0);
    drive(row(5, -6, 7, 8), 0);
    chk("max_req", p.out_data, row(5, 8, 0, 0));
    drive(row(0, 0, 0, 0), 0);
    drive(row(0, 0, 0, 0), 0);
    idle(2);
    drive(row(-1, -2, 4, 4), 1);
    drive(row(-1, 0, 8, 8), 1);
    chk("avg_req", p.out_data, row(-1, 6, 0, 0));
    drive(row(10, 20, 30, 40), 1);
    drive(row(50, 60, 70, 80), 1);
    idle(2);
    drive(row(-128, -128, 127, 127), 1); idle(3);
    drive(row(-128, -128, 127, 127), 1); idle(3);
    drive(row(-5, 100, -128, 3), 0);     idle(3);
    drive(row(-7, -9, 2, 1), 0);
    idle(2);
    drive(row(11, 22, 33, 44), 0);
    #2 resetn = 0;
    #1;
    chk("arst_data", p.out_data, 0);
    chk("arst_avail", {31'b0, p.out_data_available}, 0);
    chk("arst_done", {31'b0, p.done_pool}, 0);
    n_rows = 0;
    @(posedge clk); #1 resetn = 1;
    drive(row(3, -4, 5, -6), 0);
    drive(row(-1, 2, -3, 4), 0);
    drive(row(7, 7, 7, 7), 1);
    drive(row(-7, -7, -7, -6), 1);
    idle(2);
    p.enable_pool = 0; p.inp_data = row(9, -9, 1, 2); p.in_data_available = 1;
    #1;
    chk("byp_data", p.out_data, row(9, -9, 1, 2));
    chk("byp_avail", {31'b0, p.out_data_available}, 1);
    chk("byp_done", {31'b0, p.done_pool}, 1);
    p.in_data_available = 0;
    #1 chk("byp_idle", {31'b0, p.out_data_available}, 0);
    @(posedge clk); #1 p.enable_pool = 1;
    n_rows = 0;
    drive(row(1, 1, 1, 1), 0);
    drive(row(2, 2, 2, 2), 0);
    drive(row(3, 3, 3, 3), 0);
    p.enable_pool = 0;
    @(posedge clk); #1 p.enable_pool = 1;
    n_rows = 0;
    p.validity_mask = 4'b1110;
    drive(row(100, -3, 5, 6), 0);
    drive(row(-7, -8, 1, 1), 0);
    drive(row(90, -50, -2, -3), 1);
    drive(row(80, -60, -4, -1), 1);
    idle(3);
    chk("drain", q.size(), 0);
    chk("done_count", n_done, 5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/maxpool_avgpool_stage.md
MAXPOOL_AVGPOOL_STAGE -- requirements
Module: maxpool_avgpool_stage

Interface
REQ-001: clk  input  1  single clock; all state updates on its rising edge.
REQ-002: resetn  input  1  asynchronous, active-low reset.
REQ-003: enable_pool  input  1  1 = 2x2 pooling active; 0 = bypass.
REQ-004: pool_type  input  1  0 = max pooling, 1 = average pooling; sampled on every accepted row.
REQ-005: in_data_available  input  1  inp_data carries one valid row this cycle.
REQ-006: inp_data  input  `DESIGN_SIZE*`DWIDTH  one row; lane i at [i*`DWIDTH +: `DWIDTH], two's-complement signed.
REQ-007: validity_mask  input  `MASK_WIDTH  bit i = 0 forces lane i to 0 before pooling.
REQ-008: out_data  output  `DESIGN_SIZE*`DWIDTH  pooled row; feeds the activation stage's inp_data.
REQ-009: out_data_available  output  1  out_data valid this cycle.
REQ-010: done_pool  output  1  tile complete; feeds the activation stage's enable path.

Function
REQ-011: `DESIGN_SIZE SHALL be even and >= 2; a tile is `DESIGN_SIZE accepted rows.
REQ-012: Bypass (enable_pool=0): out_data=inp_data, out_data_available=in_data_available, done_pool=1, all combinational; internal state synchronously cleared.
REQ-013: FSM states: IDLE (expect even row), HOLD (even row reduced and stored, expect odd row), DONE.
REQ-014: IDLE + in_data_available: horizontally reduce lane pairs (2k, 2k+1) for k=0..`DESIGN_SIZE/2-1, store as partials, increment row counter, go HOLD.
REQ-015: HOLD + in_data_available: reduce odd row the same way, combine with stored partials, register result, increment row counter; go DONE if counter reaches `DESIGN_SIZE, else IDLE.
REQ-016: In IDLE/HOLD with in_data_available=0: hold state, counter and partials; out_data_available=0 (gaps of any length allowed).
REQ-017: Max: output lane k = signed max of the 4 window elements.
REQ-018: Average: sum the 4 elements in `DWIDTH+2 signed bits, arithmetic shift right by 2 (floor), truncate to `DWIDTH; no overflow possible.
REQ-019: Result lanes 0..`DESIGN_SIZE/2-1 carry pooled values; lanes `DESIGN_SIZE/2..`DESIGN_SIZE-1 SHALL be 0.
REQ-020: Latency: out_data_available pulses high exactly one cycle, the cycle after the odd row is accepted; out_data holds its value until the next result.
REQ-021: DONE lasts one cycle: done_pool=1 in that cycle (coincident with the final out_data_available), counter cleared, next state IDLE; in_data_available in DONE is accepted as the even row of the next tile.
REQ-022: pool_type change between even and odd row: value sampled at the odd row governs the combine; the even-row partial uses its own sampled value.
REQ-023: enable_pool falling mid-tile: abort, state IDLE, counter 0, partials 0; a partial tile SHALL NOT produce output.

Reset
REQ-024: resetn=0 asynchronously forces state IDLE, counter 0, partials 0, out_data 0, out_data_available 0, done_pool 0 (when enable_pool=1).
REQ-025: After resetn rises, first accepted row is treated as row 0 of a new tile.

Verification (DESIGN_SIZE=4, DWIDTH=8, mask all ones)
REQ-026: Reset: resetn=0 mid-HOLD -> out_data=0, out_data_available=0, done_pool=0 immediately; next two rows produce a fresh result.
REQ-027: Max: rows [1,2,3,4],[5,-6,7,8], then [0,0,0,0]x2 -> out [5,8,0,0] one cycle after row 2, then [0,0,0,0] with done_pool=1.
REQ-028: Average: rows [-1,-2,4,4],[-1,0,8,8] -> out [-1,6,0,0] (sums -4, 24).
REQ-029: Gaps: rows with 3 idle cycles between each -> out_data_available only after rows 2 and 4, done_pool only with the second.
REQ-030: Bypass: enable_pool=0, inp_data=[9,-9,1,2], in_data_available=1 -> out_data identical same cycle, done_pool=1.
REQ-031: Abort/mask: enable_pool dropped after row 3, re-raised, four rows with validity_mask=4'b1110 -> lane 0 treated as 0, exactly two outputs, one done_pool.
